// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: single-cycle hits, blocking line
// refill over a fixed-latency Avalon master, whole-cache invalidate for fence.i.
package icache_direct_pkg;

  typedef struct packed {
    logic        read;
    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;

endpackage

module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cache_inv,
  input  avalon_req_t  cpu_avalon_req,
  output avalon_resp_t cpu_avalon_resp,
  output avalon_req_t  mem_avalon_req,
  input  avalon_resp_t mem_avalon_resp
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [LINES-1:0]        valid_r;
  logic [TAG_W-1:0]        tag_mem_r  [LINES];
  logic [31:0]             data_mem_r [LINES][WORDS];
  logic [31:0]             line_buf_r [WORDS];
  logic [CNT_W-1:0]        issue_cnt_r;
  logic [CNT_W-1:0]        ret_cnt_r;
  logic                    pend_r;
  logic                    discard_r;
  logic [IDX_W+TAG_W-1:0]  base_r;
  logic [31:0]             rdata_r;

  logic [OFF_W-1:0]        cpu_off_s;
  logic [IDX_W-1:0]        cpu_idx_s;
  logic [TAG_W-1:0]        cpu_tag_s;
  logic [IDX_W-1:0]        fill_idx_s;
  logic [TAG_W-1:0]        fill_tag_s;
  logic                    hit_s;
  logic                    miss_s;
  logic                    cpu_wait_s;
  logic                    mem_rd_s;
  logic                    mem_acc_s;
  logic                    last_s;
  logic                    unused_s;

  assign cpu_off_s  = cpu_avalon_req.address[2 +: OFF_W];
  assign cpu_idx_s  = cpu_avalon_req.address[2 + OFF_W +: IDX_W];
  assign cpu_tag_s  = cpu_avalon_req.address[31 -: TAG_W];
  assign fill_idx_s = base_r[IDX_W-1:0];
  assign fill_tag_s = base_r[IDX_W +: TAG_W];

  assign hit_s     = cpu_avalon_req.read & valid_r[cpu_idx_s] &
                     (tag_mem_r[cpu_idx_s] == cpu_tag_s);
  assign miss_s    = (state_r == IDLE) & cpu_avalon_req.read & ~hit_s;
  assign mem_acc_s = mem_rd_s & ~mem_avalon_resp.waitrequest;
  // The last word of the line lands on the same edge that installs the line.
  assign last_s    = pend_r & (ret_cnt_r == LAST_C);

  // Writes, byte enables and the byte offset carry no meaning for a fetch cache.
  assign unused_s = ^{cpu_avalon_req.write, cpu_avalon_req.writedata,
                      cpu_avalon_req.byte_enable, cpu_avalon_req.address[1:0]};

  // Next-state and bus handshake decode.
  always_comb begin
    state_s    = state_r;
    cpu_wait_s = 1'b0;
    mem_rd_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          cpu_wait_s = 1'b1;
          state_s    = FILL;
        end else begin
          cpu_wait_s = 1'b0;
          state_s    = IDLE;
        end
      end
      FILL: begin
        cpu_wait_s = 1'b1;
        mem_rd_s   = (issue_cnt_r < WORDS_C);
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = FILL;
        end
      end
      default: begin
        state_s    = IDLE;
        cpu_wait_s = 1'b0;
        mem_rd_s   = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Refill control, valid bits and the registered hit data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r     <= '0;
      issue_cnt_r <= '0;
      ret_cnt_r   <= '0;
      pend_r      <= 1'b0;
      discard_r   <= 1'b0;
      base_r      <= '0;
      rdata_r     <= 32'h0000_0000;
    end else begin
      pend_r <= mem_acc_s;

      if ((state_r == IDLE) && hit_s) begin
        rdata_r <= data_mem_r[cpu_idx_s][cpu_off_s];
      end else begin
        rdata_r <= rdata_r;
      end

      if (miss_s) begin
        base_r <= cpu_avalon_req.address[31:2+OFF_W];
      end else begin
        base_r <= base_r;
      end

      if (last_s) begin
        issue_cnt_r <= '0;
      end else if (mem_acc_s) begin
        issue_cnt_r <= issue_cnt_r + ONE_C;
      end else begin
        issue_cnt_r <= issue_cnt_r;
      end

      if (last_s) begin
        ret_cnt_r <= '0;
      end else if (pend_r) begin
        ret_cnt_r <= ret_cnt_r + ONE_C;
      end else begin
        ret_cnt_r <= ret_cnt_r;
      end

      // An invalidate landing during or on the last edge of a refill poisons that line.
      if (last_s) begin
        if (cache_inv) begin
          valid_r <= '0;
        end else begin
          valid_r[fill_idx_s] <= ~discard_r;
        end
      end else if (cache_inv) begin
        valid_r <= '0;
      end else begin
        valid_r <= valid_r;
      end

      if (last_s) begin
        discard_r <= 1'b0;
      end else if ((state_r == FILL) && cache_inv) begin
        discard_r <= 1'b1;
      end else begin
        discard_r <= discard_r;
      end
    end
  end

  // Line buffer capture and tag/data array install.
  always_ff @(posedge clk) begin
    if (pend_r && !rst) begin
      line_buf_r[ret_cnt_r[OFF_W-1:0]] <= mem_avalon_resp.readdata;
    end
    if (last_s && !rst) begin
      tag_mem_r[fill_idx_s] <= fill_tag_s;
      for (int w = 0; w < WORDS; w++) begin
        if (w == WORDS - 1) begin
          data_mem_r[fill_idx_s][w] <= mem_avalon_resp.readdata;
        end else begin
          data_mem_r[fill_idx_s][w] <= line_buf_r[w];
        end
      end
    end
  end

  assign cpu_avalon_resp.readdata    = rdata_r;
  assign cpu_avalon_resp.waitrequest = cpu_wait_s;

  assign mem_avalon_req.read        = mem_rd_s;
  assign mem_avalon_req.address     = {base_r, issue_cnt_r[OFF_W-1:0], 2'b00};
  assign mem_avalon_req.write       = 1'b0;
  assign mem_avalon_req.writedata   = 32'h0000_0000;
  assign mem_avalon_req.byte_enable = 4'b1111;

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetch unit's Avalon ibus master and the instruction memory.
- Front side: Avalon slave to the fetch unit. Back side: Avalon master to memory.
- Hits return with no stall. Misses block while a full line is refilled by sequential single-word reads.
- Supports whole-cache invalidation for fence.i.

Parameters:
- LINES, 16, number of cache lines; power of 2, ≥2.
- WORDS, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- cache_inv  input  1  single-cycle pulse; invalidate all lines.
- cpu_avalon_req  input  avalon_req_t  fetch-side request (read, address, write, writedata, byte_enable).
- cpu_avalon_resp  output  avalon_resp_t  fetch-side response (readdata, waitrequest).
- mem_avalon_req  output  avalon_req_t  memory-side request.
- mem_avalon_resp  input  avalon_resp_t  memory-side response.

Behaviour:
- Address split, 32-bit:
  - off = addr[2 +: log2(WORDS)]
  - idx = next log2(LINES) bits
  - tag = remaining upper bits
  - addr[1:0] ignored.
- Storage: valid bit per line in flops; tag and data arrays indexed by idx.
- Bus timing, both sides: request accepted when read & ~waitrequest. readdata is valid exactly 1 cycle after acceptance (fixed latency 1). Masters hold address stable while waitrequest=1.
- FSM states: IDLE, FILL.
- IDLE:
  - hit = cpu read & valid[idx] & tag match.
  - On hit: cpu waitrequest=0; cpu readdata next cycle = data[idx][off], registered.
  - On miss: cpu waitrequest=1 combinationally; latch line base address (addr with off and [1:0] zeroed); go to FILL next cycle.
  - No cpu read: waitrequest=0.
- FILL:
  - cpu waitrequest=1 throughout.
  - Issue counter issue_cnt, 0..WORDS:
    - mem read=1 while issue_cnt<WORDS.
    - mem address = base + 4*issue_cnt; byte_enable=4'b1111; write=0.
    - issue_cnt increments on each mem acceptance.
  - Return counter ret_cnt: each cycle after an acceptance, capture mem readdata into line buffer word ret_cnt, then increment.
  - On capture of word WORDS-1 (same edge):
    - write line buffer into data[idx]; write tag; set valid[idx]=1, unless discard (below).
    - Return to IDLE.
  - Fetch unit still holds the address, so the next cycle is a hit.
  - Miss-to-data latency with zero-wait memory: 1 (miss detect) + WORDS issue + 1 return + 1 hit lookup = WORDS+3 cycles to acceptance, readdata one cycle later.
- cpu write requests: ignored (no state change), waitrequest=0.
- cache_inv:
  - In IDLE: clears all valid bits at the next edge. A hit evaluated in the same cycle still completes with the old data.
  - In FILL: clears valid bits and sets discard. The completed line is written with valid=0, so the held request re-misses and refetches. discard clears on entering IDLE.
- mem_avalon_resp.waitrequest mid-FILL: issue_cnt holds and address holds; ret_cnt captures only on data-return cycles.
- Reset, including mid-FILL:
  - State IDLE, all valid=0, counters 0, discard=0.
  - mem read=0; cpu waitrequest=0; cpu readdata=0.
  - Any memory return data arriving the cycle after reset is ignored.
- Arithmetic: counters are log2(WORDS)+1 bits; no wrap beyond WORDS. Refill address never crosses the line boundary.
- Single outstanding miss only; no hit-under-miss.

Test Plan:
- Cold miss: after reset, read 0x0000_0040, memory words 0x11,0x22,0x33,0x44 at 0x40..0x4C, zero-wait.
  - Required: mem reads at 0x40,0x44,0x48,0x4C in 4 consecutive cycles.
  - Required: cpu waitrequest high 6 cycles, then readdata=0x11.
- Hit streaming: after the above, reads 0x44,0x48,0x4C on back-to-back cycles.
  - Required: waitrequest=0 each cycle; readdata 0x22,0x33,0x44 one cycle after each; no mem reads.
- Conflict eviction (LINES=16, WORDS=4): read 0x040, then 0x140 (same idx=4, different tag), then 0x040 again.
  - Required: three refills; the third returns the original 0x040 data.
- Memory backpressure: mem waitrequest high 3 cycles on the second word of a refill.
  - Required: mem address holds at base+4 during the stall; all 4 words captured correctly; cpu data correct.
- Invalidate: inv pulse in IDLE after line 0x40 is filled, then read 0x40.
  - Required: full refill.
  - Inv pulse mid-FILL: required two complete refills of that line before cpu waitrequest drops.
- Reset mid-FILL after 2 words issued.
  - Required: mem read=0 next cycle; all valids cleared; a subsequent read of the same address performs a full 4-word refill.
